// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding bus request, a single output slot
// backed by a one-entry skid, and flush/redirect handling with stale-response drain.
package fetch_ctrl_pkg;
   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_pkt_t;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;
endpackage

module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [XLEN-1:0] pred_pc,
   input  logic            stall,
   output logic            ireq_valid,
   output logic [XLEN-1:0] ireq_addr,
   input  logic            iresp_data_ok,
   input  logic [ILEN-1:0] iresp_data,
   output logic            out_valid,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_instr,
   output logic            busy
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0] tgt_pc_q, tgt_pc_d;
   logic            slot_valid_q, slot_valid_d;
   fetch_pkt_t      slot_q, slot_d;
   fetch_pkt_t      skid_q, skid_d;
   logic            ireq_valid_q, ireq_valid_d;
   logic            busy_q, busy_d;

   logic            consumed_c;
   logic            slot_free_c;
   logic            resp_c;
   fetch_pkt_t      resp_pkt_c;

   assign consumed_c  = slot_valid_q && !stall;
   assign slot_free_c = !slot_valid_q || consumed_c;
   // A response only counts while a request is actually on the bus.
   assign resp_c      = ireq_valid_q && iresp_data_ok;
   assign resp_pkt_c  = fetch_pkt_t'{pc: req_addr_q, instr: iresp_data};

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      req_addr_d   = req_addr_q;
      tgt_pc_d     = tgt_pc_q;
      slot_valid_d = slot_valid_q && !consumed_c;
      slot_d       = slot_q;
      skid_d       = skid_q;

      unique case (state_q)
         ST_REQ: begin
            if (redirect_valid) begin
               slot_valid_d = 1'b0;
               if (resp_c || !ireq_valid_q) begin
                  req_addr_d = redirect_pc;
               end else begin
                  tgt_pc_d = redirect_pc;
                  state_d  = ST_DRAIN;
               end
            end else if (resp_c) begin
               req_addr_d = pred_pc;
               if (slot_free_c) begin
                  slot_valid_d = 1'b1;
                  slot_d       = resp_pkt_c;
               end else begin
                  skid_d  = resp_pkt_c;
                  state_d = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            if (redirect_valid) begin
               slot_valid_d = 1'b0;
               req_addr_d   = redirect_pc;
               state_d      = ST_REQ;
            end else if (consumed_c) begin
               slot_valid_d = 1'b1;
               slot_d       = skid_q;
               state_d      = ST_REQ;
            end
         end

         ST_DRAIN: begin
            slot_valid_d = 1'b0;
            if (redirect_valid) begin
               tgt_pc_d = redirect_pc;
            end
            // Stale response is dropped; the newest redirect target wins.
            if (resp_c) begin
               req_addr_d = redirect_valid ? redirect_pc : tgt_pc_q;
               state_d    = ST_REQ;
            end
         end

         default: begin
            slot_valid_d = 1'b0;
            state_d      = ST_REQ;
         end
      endcase

      ireq_valid_d = (state_d != ST_HOLD);
      busy_d       = (state_d == ST_DRAIN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_REQ;
         req_addr_q   <= RESET_PC;
         tgt_pc_q     <= '0;
         slot_valid_q <= 1'b0;
         slot_q       <= '0;
         skid_q       <= '0;
         ireq_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_addr_q   <= req_addr_d;
         tgt_pc_q     <= tgt_pc_d;
         slot_valid_q <= slot_valid_d;
         slot_q       <= slot_d;
         skid_q       <= skid_d;
         ireq_valid_q <= ireq_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign ireq_valid = ireq_valid_q;
   assign ireq_addr  = req_addr_q;
   assign out_valid  = slot_valid_q;
   assign out_pc     = slot_q.pc;
   assign out_instr  = slot_q.instr;
   assign busy       = busy_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a per-cycle vector table plus a hand-written
// mid-cycle asynchronous reset sequence.
module tb_fetch_ctrl;

   localparam logic [63:0] RP = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic [63:0] pred_pc = '0;
   logic        stall = 1'b0;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok = 1'b0;
   logic [31:0] iresp_data = '0;
   logic        out_valid;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   fetch_ctrl #(.RESET_PC(RP)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pred_pc        (pred_pc),
      .stall          (stall),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rv;
      logic [63:0] rpc;
      logic [63:0] ppc;
      logic        st;
      logic        ok;
      logic [31:0] d;
      logic        e_iv;
      logic [63:0] e_a;
      logic        e_ov;
      logic [63:0] e_pc;
      logic [31:0] e_in;
      logic        e_b;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic rst, input logic rv, input logic [31:0] rpc,
                               input logic [31:0] ppc, input logic st, input logic ok,
                               input logic [31:0] d, input logic e_iv, input logic [31:0] e_a,
                               input logic e_ov, input logic [31:0] e_pc,
                               input logic [31:0] e_in, input logic e_b);
      vec_t v;
      v.rst = rst;  v.rv = rv;  v.rpc = {32'h0, rpc};  v.ppc = {32'h0, ppc};
      v.st = st;    v.ok = ok;  v.d = d;
      v.e_iv = e_iv; v.e_a = {32'h0, e_a}; v.e_ov = e_ov;
      v.e_pc = {32'h0, e_pc}; v.e_in = e_in; v.e_b = e_b;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   initial begin
      // rst rv rpc          ppc          st ok data          | iv addr         ov pc           instr         busy
      add(0, 0, 0,           0,           0, 0, 0,            0, 32'h8000_0000, 0, 0,           0,            0);
      add(0, 0, 0,           0,           0, 0, 0,            0, 32'h8000_0000, 0, 0,           0,            0);
      add(1, 0, 0,           0,           0, 0, 0,            0, 32'h8000_0000, 0, 0,           0,            0);
      add(1, 0, 0,           32'h8000_0004, 0, 1, 32'h1111_0000, 1, 32'h8000_0000, 0, 0,       0,            0);
      add(1, 0, 0,           32'h8000_0008, 0, 1, 32'h1111_0004, 1, 32'h8000_0004, 1, 32'h8000_0000, 32'h1111_0000, 0);
      add(1, 0, 0,           32'h8000_000C, 0, 1, 32'h1111_0008, 1, 32'h8000_0008, 1, 32'h8000_0004, 32'h1111_0004, 0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_000C, 1, 32'h8000_0008, 32'h1111_0008, 0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_000C, 0, 0,           0,            0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_000C, 0, 0,           0,            0);
      add(1, 0, 0,           32'h8000_0010, 0, 1, 32'h1111_000C, 1, 32'h8000_000C, 0, 0,       0,            0);
      // stalled slot pushes the next response into the skid
      add(1, 0, 0,           32'h8000_0014, 1, 1, 32'h1111_0010, 1, 32'h8000_0010, 1, 32'h8000_000C, 32'h1111_000C, 0);
      add(1, 0, 0,           0,           1, 0, 0,            0, 32'h8000_0014, 1, 32'h8000_000C, 32'h1111_000C, 0);
      add(1, 0, 0,           0,           0, 0, 0,            0, 32'h8000_0014, 1, 32'h8000_000C, 32'h1111_000C, 0);
      // redirect together with a response: response dropped, no drain
      add(1, 1, 32'h8000_0010, 0,         0, 1, 32'hDEAD_0014, 1, 32'h8000_0014, 1, 32'h8000_0010, 32'h1111_0010, 0);
      add(1, 1, 32'h8000_1000, 0,         0, 0, 0,            1, 32'h8000_0010, 0, 0,           0,            0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_0010, 0, 0,           0,            1);
      add(1, 0, 0,           32'h8000_0014, 0, 1, 32'hDEAD_0010, 1, 32'h8000_0010, 0, 0,       0,            1);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_1000, 0, 0,           0,            0);
      add(1, 0, 0,           32'h8000_1004, 0, 1, 32'h2222_1000, 1, 32'h8000_1000, 0, 0,       0,            0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_1004, 1, 32'h8000_1000, 32'h2222_1000, 0);
      // back-to-back redirects while draining: latest target wins
      add(1, 1, 32'h8000_2000, 0,         0, 0, 0,            1, 32'h8000_1004, 0, 0,           0,            0);
      add(1, 1, 32'h8000_3000, 0,         0, 0, 0,            1, 32'h8000_1004, 0, 0,           0,            1);
      add(1, 0, 0,           0,           0, 1, 32'hDEAD_1004, 1, 32'h8000_1004, 0, 0,           0,            1);
      add(1, 1, 32'h8000_4000, 0,         0, 0, 0,            1, 32'h8000_3000, 0, 0,           0,            0);
      add(1, 1, 32'h8000_5000, 0,         0, 1, 32'hDEAD_3000, 1, 32'h8000_3000, 0, 0,           0,            1);
      add(1, 0, 0,           32'h8000_5004, 0, 1, 32'h3333_5000, 1, 32'h8000_5000, 0, 0,       0,            0);
      add(1, 0, 0,           32'h8000_5008, 1, 1, 32'h3333_5004, 1, 32'h8000_5004, 1, 32'h8000_5000, 32'h3333_5000, 0);
      // redirect in HOLD drops slot and skid
      add(1, 1, 32'h8000_6000, 0,         1, 0, 0,            0, 32'h8000_5008, 1, 32'h8000_5000, 32'h3333_5000, 0);
      add(1, 0, 0,           32'h8000_6004, 0, 1, 32'h4444_6000, 1, 32'h8000_6000, 0, 0,       0,            0);
      add(1, 0, 0,           0,           1, 0, 0,            1, 32'h8000_6004, 1, 32'h8000_6000, 32'h4444_6000, 0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_6004, 1, 32'h8000_6000, 32'h4444_6000, 0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_6004, 0, 0,           0,            0);
      add(1, 1, 32'h8000_7000, 0,         0, 0, 0,            1, 32'h8000_6004, 0, 0,           0,            0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_6004, 0, 0,           0,            1);
      // reset while draining: immediate reset values, restart at RESET_PC
      add(0, 0, 0,           0,           0, 0, 0,            0, 32'h8000_0000, 0, 0,           0,            0);
      add(1, 0, 0,           0,           0, 0, 0,            0, 32'h8000_0000, 0, 0,           0,            0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_0000, 0, 0,           0,            0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_0000, 0, 0,           0,            0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_0000, 0, 0,           0,            0);
      add(1, 0, 0,           32'h8000_0004, 0, 1, 32'h5555_0000, 1, 32'h8000_0000, 0, 0,       0,            0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_0004, 1, 32'h8000_0000, 32'h5555_0000, 0);
      add(1, 0, 0,           0,           0, 0, 0,            1, 32'h8000_0004, 0, 0,           0,            0);

      #1 reset = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         reset          = tbl[i].rst;
         redirect_valid = tbl[i].rv;
         redirect_pc    = tbl[i].rpc;
         pred_pc        = tbl[i].ppc;
         stall          = tbl[i].st;
         iresp_data_ok  = tbl[i].ok;
         iresp_data     = tbl[i].d;
         #1;
         chk($sformatf("v%0d ireq_valid", i), 64'(ireq_valid), 64'(tbl[i].e_iv));
         chk($sformatf("v%0d ireq_addr", i), ireq_addr, tbl[i].e_a);
         chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].e_b));
         if (tbl[i].e_ov || !tbl[i].rst) begin
            chk($sformatf("v%0d out_pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("v%0d out_instr", i), 64'(out_instr), 64'(tbl[i].e_in));
         end
      end

      // Reset asserted between clock edges with a full slot.
      @(negedge clk);
      stall         = 1'b1;
      iresp_data_ok = 1'b1;
      iresp_data    = 32'h6666_0004;
      pred_pc       = 64'h0000_0000_8000_0008;
      @(posedge clk);
      #2;
      iresp_data_ok = 1'b0;
      chk("mid out_valid", 64'(out_valid), 64'd1);
      chk("mid out_pc", out_pc, 64'h0000_0000_8000_0004);
      chk("mid out_instr", 64'(out_instr), 64'h6666_0004);
      chk("mid ireq_addr", ireq_addr, 64'h0000_0000_8000_0008);
      #1 reset = 1'b0;
      #1;
      chk("async ireq_valid", 64'(ireq_valid), 64'd0);
      chk("async ireq_addr", ireq_addr, RP);
      chk("async out_valid", 64'(out_valid), 64'd0);
      chk("async out_pc", out_pc, 64'd0);
      chk("async out_instr", 64'(out_instr), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      stall = 1'b0;
      #1;
      chk("release ireq_valid", 64'(ireq_valid), 64'd0);
      @(negedge clk);
      #1;
      chk("restart ireq_valid", 64'(ireq_valid), 64'd1);
      chk("restart ireq_addr", ireq_addr, RP);
      chk("restart busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clk.
REQ-004 redirect_valid  input  1  flush and restart fetch at redirect_pc (branch resolve/exception).
REQ-005 redirect_pc  input  64  restart address, valid when redirect_valid=1.
REQ-006 pred_pc  input  64  predicted next PC for the instruction returning this cycle (computed outside from ireq_addr and iresp_data).
REQ-007 stall  input  1  downstream cannot accept out slot this cycle.
REQ-008 ireq_valid  output  1  instruction bus request.
REQ-009 ireq_addr  output  64  request address.
REQ-010 iresp_data_ok  input  1  response for the outstanding request is returned this cycle.
REQ-011 iresp_data  input  32  raw instruction, valid with iresp_data_ok.
REQ-012 out_valid  output  1  out slot holds a valid fetched instruction.
REQ-013 out_pc  output  64  PC of slot instruction.
REQ-014 out_instr  output  32  slot instruction.
REQ-015 busy  output  1  1 in DRAIN state (stale request outstanding).

Function
REQ-016 States: REQ, HOLD, DRAIN; registers req_addr(64), tgt_pc(64), slot (valid/pc/instr), skid (pc/instr).
REQ-017 Bus rule: once ireq_valid=1, ireq_valid and ireq_addr stay constant until the cycle iresp_data_ok=1 inclusive; ireq_addr=req_addr always.
REQ-018 Slot consumed in any cycle with out_valid=1 and stall=0; slot "free" = out_valid=0 or consumed.
REQ-019 REQ: ireq_valid=1; iresp_data_ok=1, redirect_valid=0, slot free -> slot<= {req_addr,iresp_data}, req_addr<=pred_pc, stay REQ (back-to-back, one instruction per cycle).
REQ-020 REQ: iresp_data_ok=1, redirect_valid=0, slot not free -> skid<= {req_addr,iresp_data}, req_addr<=pred_pc, go HOLD.
REQ-021 HOLD: ireq_valid=0; when slot consumed -> slot<=skid, out_valid stays 1, go REQ.
REQ-022 Slot-to-output latency: instruction appears on out_* the cycle after its iresp_data_ok.
REQ-023 Redirect in REQ with iresp_data_ok=1: response discarded, req_addr<=redirect_pc, out_valid<=0, stay REQ.
REQ-024 Redirect in REQ with iresp_data_ok=0: tgt_pc<=redirect_pc, out_valid<=0, go DRAIN; request to old req_addr continues per REQ-017.
REQ-025 DRAIN: ireq_valid=1 on old req_addr; on iresp_data_ok response discarded, req_addr<=tgt_pc, go REQ; new request issued next cycle.
REQ-026 Redirect in DRAIN: tgt_pc<=redirect_pc (latest wins); if same cycle as iresp_data_ok, req_addr<=redirect_pc, go REQ.
REQ-027 Redirect in HOLD: skid and slot dropped, out_valid<=0, req_addr<=redirect_pc, go REQ.
REQ-028 Redirect has priority over stall, slot consumption and skid transfer; a slot consumed in the redirect cycle counts as delivered.
REQ-029 No instruction from a request issued before a redirect ever reaches out_valid=1 after that redirect.
REQ-030 pred_pc sampled only in cycles where a non-discarded response is accepted.

Reset
REQ-031 reset=0: state<=REQ, req_addr<=RESET_PC, tgt_pc<=0, out_valid<=0, out_pc<=0, out_instr<=0, skid<=0, busy=0.
REQ-032 ireq_valid=0 while reset=0; ireq_valid=1 with ireq_addr=RESET_PC from the first clk edge after reset deasserts.
REQ-033 Reset asserted mid-request or in DRAIN abandons the request; no outstanding-response tracking survives reset.

Verification
REQ-034 Reset release, data_ok every cycle, pred_pc=addr+4, stall=0 -> out_pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles.
REQ-035 data_ok delayed 3 cycles -> ireq_addr held at 0x80000000 all 4 cycles, out_valid=1 exactly one cycle after data_ok.
REQ-036 stall=1 while slot full and next response arrives -> state HOLD, ireq_valid=0; stall drops -> skid instr on out next cycle, request resumes at pred_pc.
REQ-037 redirect to 0x80001000 while request to 0x80000010 outstanding, data_ok 2 cycles later -> busy=1, old data never on out, next ireq_addr=0x80001000.
REQ-038 redirect and data_ok same cycle in REQ -> data dropped, ireq_addr=redirect_pc next cycle, busy=0.
REQ-039 reset pulsed low in DRAIN -> outputs at reset values immediately, fetch restarts at RESET_PC.
